// File: rtl/decrypt_sequencer.sv
// Drives one decrypt pass: walks ROM addresses, delays them to match core latency,
// and shares the frame-buffer port with VGA scan-out. Optional checksum: DECRYPT_SEQ_CHECKSUM_EN.
//
// state | meaning
// IDLE  | frame port owned by VGA, waiting for start
// RUN   | issuing ROM reads, one address per cycle
// DRAIN | reads finished, waiting for in-flight bytes to be written
// DONE  | pass complete, frame port back to VGA
module decrypt_sequencer #(
  parameter int PIXELS = 30625,
  parameter int ADDR_W = 15,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        key_in,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              core_en,
  output logic [7:0]        core_key,
  input  logic [7:0]        core_data,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_blank,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_we,
  output logic [7:0]        fb_wdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  // Every stage except the tail; when these are empty the tail holds the final write.
  localparam logic [LAT-1:0]    HEAD_MASK = LAT'((1 << (LAT - 1)) - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        key_q;
  logic [LAT-1:0]    vld_q;
  logic [ADDR_W-1:0] pipe_addr_q [LAT];

  logic idle_like, active, start_ok;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign start_ok  = idle_like && start && !abort;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN: begin
        if (abort)                    state_d = S_IDLE;
        else if (addr_q == LAST_ADDR) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                          state_d = S_IDLE;
        else if ((vld_q & HEAD_MASK) == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (start_ok)   state_d = S_RUN;
        else if (abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_en    = (state_q == S_RUN);
    rom_addr  = addr_q;
    core_en   = active;
    core_key  = key_q;
    busy      = active;
    done      = (state_q == S_DONE);
    vga_blank = active;
    fb_we     = active && vld_q[LAT-1];
    fb_addr   = active ? pipe_addr_q[LAT-1] : vga_addr;
    fb_wdata  = core_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      key_q  <= '0;
    end else if (start_ok) begin
      addr_q <= '0;
      key_q  <= key_in;
    end else if (state_q == S_RUN && addr_q != LAST_ADDR) begin
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok || (active && abort)) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rom_en;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Addresses travel alongside the valids; only the valids need clearing.
  always_ff @(posedge clk) begin
    pipe_addr_q[0] <= addr_q;
    for (int i = 1; i < LAT; i++) pipe_addr_q[i] <= pipe_addr_q[i-1];
  end

`ifdef DECRYPT_SEQ_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) csum_q <= '0;
    else if (fb_we)      csum_q <= csum_q ^ core_data;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/decrypt_sequencer.md
# decrypt_sequencer

Controls one decryption pass over the 175×175 encrypted image.
- Walks every pixel address of the encrypted ROM and keeps the XOR decrypt core enabled and keyed.
- Tracks the core's pipeline latency so each decrypted byte is written to the frame buffer at the matching address.
- Shares the single frame-buffer port between decrypt writes and VGA scan-out reads.
- Sits between the top-level control (button/start logic), the encrypted ROM, the decrypt core and the frame BRAM.

## Interface
Parameters:
- PIXELS, 30625, number of pixel bytes per pass (175×175)
- ADDR_W, 15, address width of ROM and frame buffer
- LAT, 2, cycles from rom_en to valid core_data (ROM 1 + core 1); legal range 1–4

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a pass; sampled in IDLE or DONE only
- abort  in  1  cancel a pass in progress; wins over start
- key_in  in  8  decrypt key, latched on accepted start
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM read address
- core_en  out  1  decrypt core enable
- core_key  out  8  latched key to core
- core_data  in  8  decrypted byte, valid LAT cycles after its rom_en
- vga_addr  in  ADDR_W  scan-out read address
- vga_blank  out  1  VGA must output black (frame buffer owned by decrypt)
- fb_addr  out  ADDR_W  frame-buffer port address
- fb_we  out  1  frame-buffer write enable
- fb_wdata  out  8  frame-buffer write data (= core_data)
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- checksum  out  8  XOR of all bytes written this pass (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE + start (abort low) → RUN.
  - Latch key_in into core_key.
  - Clear pipeline and checksum.
  - rom_addr=0.
- RUN: rom_en=1 each cycle; rom_addr increments by 1 per cycle.
  - The cycle that issues address PIXELS-1 is the last RUN cycle → DRAIN.
  - rom_addr holds PIXELS-1 after that; it never wraps.
- DRAIN: rom_en=0. Stay until all in-flight addresses are written → DONE.
- DONE: done=1 until the next accepted start, abort or rst.
- abort in RUN/DRAIN → IDLE next cycle.
  - All pipeline valids cleared; no fb_we after abort is sampled.
  - done stays 0.
- abort in IDLE/DONE: no effect except clearing done (DONE → IDLE).
- start in RUN/DRAIN: ignored.
- Write pipeline: LAT-deep shift of {valid, addr}. fb_we = tail valid, fb_addr = tail addr.
- core_en=1 in RUN and DRAIN, 0 otherwise.
- Arbitration is by state only.
  - RUN/DRAIN: frame port belongs to the pipeline; vga_blank=1.
  - IDLE/DONE: fb_addr = vga_addr (combinational), fb_we=0, vga_blank=0.
- fb_wdata = core_data combinationally in all states.

## Timing
- Reset values: state IDLE; rom_en 0, rom_addr 0, core_en 0, core_key 0, fb_we 0, vga_blank 0, busy 0, done 0, checksum 0. Pipeline valids cleared.
- Start sampled at edge 0:
  - rom_en cycles 1..PIXELS with addresses 0..PIXELS-1.
  - fb_we cycles 1+LAT..PIXELS+LAT with addresses 0..PIXELS-1.
  - done=1 and busy=0 from cycle PIXELS+LAT+1.
- Exactly PIXELS writes per uninterrupted pass; no duplicates, no gaps.
- rst mid-pass: reset values next cycle; no further writes.

## Configuration
- Macro DECRYPT_SEQ_CHECKSUM_EN.
- Defined:
  - checksum cleared on accepted start.
  - checksum ^= core_data on every fb_we cycle.
  - Value is final when done rises and holds until next start/rst.
- Undefined: checksum tied to 0; no checksum logic.

## Test plan
- Reset then idle, vga_addr=100 → fb_addr=100, fb_we=0, vga_blank=0, done=0.
- PIXELS=16, LAT=2; start with key_in=8'hB3; ROM model returns addr[7:0], core model XORs with key, 1-cycle latency.
  - 16 writes, addresses 0..15, data addr^8'hB3.
  - done rises at cycle 19.
  - With DECRYPT_SEQ_CHECKSUM_EN: checksum=8'h00 (XOR of 0..15 is 0; 16 copies of B3 cancel).
- Start again while busy at cycle 5 → ignored; still exactly 16 writes; key unchanged.
- Abort at cycle 8 of the PIXELS=16 run → IDLE at cycle 9, no fb_we from cycle 9, done=0, vga_blank=0.
- Same cycle start+abort in DONE → IDLE, no pass starts; rst at cycle 10 of a pass → all outputs reset values at cycle 11.
- Default PIXELS=30625 full pass → 30625 writes, last address 30624, done at cycle 30628, rom_addr never exceeds 30624.
